cp0_regfile: RTL and testbench

Coprocessor-0 register file and exception-state holder for the 5-stage MIPS core. It consumes the write-back stage's CP0 bus, which carries exception commit, ERET commit and MTC0 write, and returns MFC0 read data for the instruction currently in write-back. It also produces the exception/ERET redirect target and the interrupt request sampled by the front end. It implements BadVAddr (8), Count (9), Compare (11), Status (12), Cause (13) and EPC (14).

---
 rtl/cp0_if.sv | 20 ++
 rtl/cp0_regfile.sv | 168 ++++++++++++++++
 tb/tb_cp0_regfile.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/cp0_if.sv
// Write-back to CP0 bus plus the CP0 results returned to the pipeline.
// The pipeline side uses master; the CP0 block uses slave.
interface cp0_if;
   logic [109:0] wb_to_cp0_bus;
   logic [5:0]   ext_int;
   logic [31:0]  cp0_rdata;
   logic [31:0]  flush_target;
   logic [31:0]  cp0_epc;
   logic         int_req;

   modport master (
      output wb_to_cp0_bus, ext_int,
      input  cp0_rdata, flush_target, cp0_epc, int_req
   );

   modport slave (
      input  wb_to_cp0_bus, ext_int,
      output cp0_rdata, flush_target, cp0_epc, int_req
   );
endinterface

// File: rtl/cp0_regfile.sv
// CP0 register file: BadVAddr, Count, Compare, Status, Cause and EPC.
// Handles exception/ERET/MTC0 commits from write-back and the timer interrupt.
module cp0_regfile #(
   parameter logic [31:0] EX_VECTOR = 32'hBFC0_0380
) (
   input logic clk,
   input logic reset,
   cp0_if.slave bus
);
   logic        eret_s, mtc0_we_s, bd_s, ex_s;
   logic [31:0] rt_value_s, pc_s, badvaddr_s;
   logic [4:0]  cp0_addr_s, excode_s;
   logic        do_mtc0_s, wr_count_s, wr_compare_s, bad_addr_exc_s;

   logic [31:0] badvaddr_r, count_r, compare_r, epc_r;
   logic [7:0]  im_r;
   logic        exl_r, ie_r, bd_r, ti_r, tick_r, int_req_r;
   logic [5:0]  ip_hw_r;
   logic [1:0]  ip_sw_r;
   logic [4:0]  exccode_r;

   logic [31:0] badvaddr_n, count_n, compare_n, epc_n;
   logic [7:0]  im_n;
   logic        exl_n, ie_n, bd_n, ti_n, int_req_n;
   logic [5:0]  ip_hw_n;
   logic [1:0]  ip_sw_n;
   logic [4:0]  exccode_n;

   logic [31:0] status_s, cause_s;

   assign eret_s     = bus.wb_to_cp0_bus[0];
   assign rt_value_s = bus.wb_to_cp0_bus[32:1];
   assign cp0_addr_s = bus.wb_to_cp0_bus[37:33];
   assign mtc0_we_s  = bus.wb_to_cp0_bus[38];
   assign pc_s       = bus.wb_to_cp0_bus[70:39];
   assign bd_s       = bus.wb_to_cp0_bus[71];
   assign badvaddr_s = bus.wb_to_cp0_bus[103:72];
   assign excode_s   = bus.wb_to_cp0_bus[108:104];
   assign ex_s       = bus.wb_to_cp0_bus[109];

   // Priority ex > eret > mtc0: lower-priority actions are dropped entirely.
   assign do_mtc0_s      = mtc0_we_s & ~ex_s & ~eret_s;
   assign wr_count_s     = do_mtc0_s & (cp0_addr_s == 5'd9);
   assign wr_compare_s   = do_mtc0_s & (cp0_addr_s == 5'd11);
   assign bad_addr_exc_s = (excode_s == 5'd4) | (excode_s == 5'd5);

   assign status_s = {9'd0, 1'b1, 6'd0, im_r, 6'd0, exl_r, ie_r};
   assign cause_s  = {bd_r, ti_r, 14'd0, ip_hw_r, ip_sw_r, 1'b0, exccode_r, 2'b00};

   assign bus.flush_target = ex_s ? EX_VECTOR : epc_r;
   assign bus.cp0_epc      = epc_r;
   assign bus.int_req      = int_req_r;

   // MFC0 read mux over stored state.
   always_comb begin
      bus.cp0_rdata = 32'd0;
      case (cp0_addr_s)
         5'd8:    bus.cp0_rdata = badvaddr_r;
         5'd9:    bus.cp0_rdata = count_r;
         5'd11:   bus.cp0_rdata = compare_r;
         5'd12:   bus.cp0_rdata = status_s;
         5'd13:   bus.cp0_rdata = cause_s;
         5'd14:   bus.cp0_rdata = epc_r;
         default: bus.cp0_rdata = 32'd0;
      endcase
   end

   // Next-state computation for every CP0 register.
   always_comb begin
      badvaddr_n = badvaddr_r;
      compare_n  = compare_r;
      epc_n      = epc_r;
      im_n       = im_r;
      exl_n      = exl_r;
      ie_n       = ie_r;
      bd_n       = bd_r;
      ip_sw_n    = ip_sw_r;
      exccode_n  = exccode_r;
      ip_hw_n    = {ti_r | bus.ext_int[5], bus.ext_int[4:0]};

      if (wr_count_s) begin
         count_n = rt_value_s;
      end else if (tick_r) begin
         count_n = count_r + 32'd1;
      end else begin
         count_n = count_r;
      end

      if (wr_compare_s) begin
         ti_n = 1'b0;
      end else if (count_r == compare_r) begin
         ti_n = 1'b1;
      end else begin
         ti_n = ti_r;
      end

      if (ex_s) begin
         exl_n     = 1'b1;
         exccode_n = excode_s;
         // A nested exception keeps the original EPC/BD so ERET returns to the outer fault.
         if (!exl_r) begin
            epc_n = bd_s ? (pc_s - 32'd4) : pc_s;
            bd_n  = bd_s;
         end else begin
            epc_n = epc_r;
            bd_n  = bd_r;
         end
         if (bad_addr_exc_s) begin
            badvaddr_n = badvaddr_s;
         end else begin
            badvaddr_n = badvaddr_r;
         end
      end else if (eret_s) begin
         exl_n = 1'b0;
      end else if (do_mtc0_s) begin
         case (cp0_addr_s)
            5'd11: compare_n = rt_value_s;
            5'd12: begin
               im_n  = rt_value_s[15:8];
               exl_n = rt_value_s[1];
               ie_n  = rt_value_s[0];
            end
            5'd13:   ip_sw_n = rt_value_s[9:8];
            5'd14:   epc_n   = rt_value_s;
            default: epc_n   = epc_r;
         endcase
      end else begin
         exl_n = exl_r;
      end

      int_req_n = (|({ip_hw_r, ip_sw_r} & im_r)) & ie_r & ~exl_r;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         badvaddr_r <= 32'd0;
         count_r    <= 32'd0;
         compare_r  <= 32'd0;
         epc_r      <= 32'd0;
         im_r       <= 8'd0;
         exl_r      <= 1'b0;
         ie_r       <= 1'b0;
         bd_r       <= 1'b0;
         ti_r       <= 1'b0;
         ip_hw_r    <= 6'd0;
         ip_sw_r    <= 2'd0;
         exccode_r  <= 5'd0;
         tick_r     <= 1'b0;
         int_req_r  <= 1'b0;
      end else begin
         badvaddr_r <= badvaddr_n;
         count_r    <= count_n;
         compare_r  <= compare_n;
         epc_r      <= epc_n;
         im_r       <= im_n;
         exl_r      <= exl_n;
         ie_r       <= ie_n;
         bd_r       <= bd_n;
         ti_r       <= ti_n;
         ip_hw_r    <= ip_hw_n;
         ip_sw_r    <= ip_sw_n;
         exccode_r  <= exccode_n;
         tick_r     <= ~tick_r;
         int_req_r  <= int_req_n;
      end
   end
endmodule

// File: tb/tb_cp0_regfile.sv
// Directed self-checking bench for cp0_regfile with hand-computed expectations.
module tb_cp0_regfile;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;
   int   n;

   cp0_if bus_if ();

   cp0_regfile dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #10 clk = ~clk;

   function automatic logic [109:0] mk(input logic ex, input logic [4:0] excode,
                                       input logic [31:0] bva, input logic bd,
                                       input logic [31:0] pc, input logic we,
                                       input logic [4:0] addr, input logic [31:0] rt,
                                       input logic eret);
      return {ex, excode, bva, bd, pc, we, addr, rt, eret};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
      bus_if.wb_to_cp0_bus = mk(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, a, 32'd0, 1'b0);
      #1;
      chk(tag, bus_if.cp0_rdata, exp);
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] v);
      bus_if.wb_to_cp0_bus = mk(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, a, v, 1'b0);
      step();
      bus_if.wb_to_cp0_bus = 110'd0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      bus_if.wb_to_cp0_bus = 110'd0;
      bus_if.ext_int = 6'd0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state, all read within the first cycle after release
      rd(5'd8,  32'h0000_0000, "rst_badvaddr");
      rd(5'd9,  32'h0000_0000, "rst_count");
      rd(5'd11, 32'h0000_0000, "rst_compare");
      rd(5'd12, 32'h0040_0000, "rst_status");
      rd(5'd13, 32'h0000_0000, "rst_cause");
      rd(5'd14, 32'h0000_0000, "rst_epc");
      rd(5'd10, 32'h0000_0000, "rst_unmapped");
      chk("rst_int_req", {31'd0, bus_if.int_req}, 32'd0);
      chk("rst_cp0_epc", bus_if.cp0_epc, 32'd0);
      chk("rst_flush", bus_if.flush_target, 32'd0);

      step(); step();
      rd(5'd9, 32'd1, "count_2cyc");
      step(); step();
      rd(5'd9, 32'd2, "count_4cyc");

      // Park Compare far away so the reset-time match TI drains out
      wr(5'd11, 32'hFFFF_0000);
      step();
      rd(5'd13, 32'h0000_0000, "cause_cleared");

      // Exception in delay slot with AdEL
      bus_if.wb_to_cp0_bus = mk(1'b1, 5'd4, 32'h0000_1003, 1'b1, 32'hBFC0_0100,
                                1'b0, 5'd0, 32'd0, 1'b0);
      #1;
      chk("ex_flush_vec", bus_if.flush_target, 32'hBFC0_0380);
      step();
      rd(5'd14, 32'hBFC0_00FC, "ex1_epc");
      chk("ex1_cp0_epc", bus_if.cp0_epc, 32'hBFC0_00FC);
      rd(5'd13, 32'h8000_0010, "ex1_cause");
      rd(5'd8,  32'h0000_1003, "ex1_badvaddr");
      rd(5'd12, 32'h0040_0002, "ex1_status");

      // Nested exception while EXL=1
      bus_if.wb_to_cp0_bus = mk(1'b1, 5'd8, 32'h0000_DEAD, 1'b0, 32'h0000_0200,
                                1'b0, 5'd0, 32'd0, 1'b0);
      step();
      rd(5'd14, 32'hBFC0_00FC, "ex2_epc_kept");
      rd(5'd13, 32'h8000_0020, "ex2_cause");
      rd(5'd8,  32'h0000_1003, "ex2_badvaddr_kept");

      // ERET with a simultaneous MTC0 to EPC that must be dropped
      bus_if.wb_to_cp0_bus = mk(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 5'd14,
                                32'h0000_5555, 1'b1);
      #1;
      chk("eret_flush_epc", bus_if.flush_target, 32'hBFC0_00FC);
      step();
      rd(5'd12, 32'h0040_0000, "eret_status");
      rd(5'd14, 32'hBFC0_00FC, "eret_epc_kept");

      // Exception beats MTC0 to EPC in the same cycle
      bus_if.wb_to_cp0_bus = mk(1'b1, 5'd0, 32'd0, 1'b0, 32'h0040_0020, 1'b1, 5'd14,
                                32'h0000_1234, 1'b0);
      step();
      rd(5'd14, 32'h0040_0020, "exmtc0_epc");
      rd(5'd13, 32'h0000_0000, "exmtc0_cause");
      rd(5'd12, 32'h0040_0002, "exmtc0_status");

      // Write masks and ignored addresses
      wr(5'd12, 32'hFFFF_FFFF);
      rd(5'd12, 32'h0040_FF03, "status_mask");
      wr(5'd13, 32'hFFFF_FFFF);
      rd(5'd13, 32'h0000_0300, "cause_mask");
      wr(5'd8, 32'h0000_0077);
      rd(5'd8, 32'h0000_1003, "badvaddr_ro");
      wr(5'd12, 32'h0000_8001);
      rd(5'd12, 32'h0040_8001, "status_8001");
      chk("int_req_exl_masked", {31'd0, bus_if.int_req}, 32'd0);
      wr(5'd13, 32'h0000_0000);
      rd(5'd13, 32'h0000_0000, "cause_sw_clear");

      // Timer interrupt
      wr(5'd11, 32'd5);
      wr(5'd9, 32'd3);
      rd(5'd9, 32'd3, "count_written");
      n = 0;
      while (bus_if.cp0_rdata != 32'd5 && n < 20) begin
         step();
         n++;
      end
      chk("count_reach5", bus_if.cp0_rdata, 32'd5);
      rd(5'd13, 32'h0000_0000, "ti_not_yet");
      step();
      rd(5'd13, 32'h4000_0000, "ti_set");
      chk("int_req_ti0", {31'd0, bus_if.int_req}, 32'd0);
      step();
      rd(5'd13, 32'h4000_8000, "ip15_set");
      chk("int_req_ti1", {31'd0, bus_if.int_req}, 32'd0);
      step();
      chk("int_req_timer", {31'd0, bus_if.int_req}, 32'd1);
      wr(5'd11, 32'hFFFF_0000);
      rd(5'd13, 32'h0000_8000, "ti_cleared");
      step();
      rd(5'd13, 32'h0000_0000, "ip15_cleared");
      chk("int_req_drain", {31'd0, bus_if.int_req}, 32'd1);
      step();
      chk("int_req_timer_off", {31'd0, bus_if.int_req}, 32'd0);

      // External interrupt line 0
      wr(5'd12, 32'h0000_0401);
      rd(5'd12, 32'h0040_0401, "status_im10");
      bus_if.ext_int = 6'b00_0001;
      step();
      rd(5'd13, 32'h0000_0400, "ip10_set");
      chk("int_req_ext0", {31'd0, bus_if.int_req}, 32'd0);
      step();
      chk("int_req_ext1", {31'd0, bus_if.int_req}, 32'd1);
      wr(5'd12, 32'h0000_0403);
      chk("int_req_exl_lag", {31'd0, bus_if.int_req}, 32'd1);
      rd(5'd12, 32'h0040_0403, "status_exl_set");
      step();
      chk("int_req_exl_off", {31'd0, bus_if.int_req}, 32'd0);
      bus_if.ext_int = 6'd0;

      // Count wraparound
      wr(5'd9, 32'hFFFF_FFFF);
      rd(5'd9, 32'hFFFF_FFFF, "count_max");
      n = 0;
      while (bus_if.cp0_rdata == 32'hFFFF_FFFF && n < 5) begin
         step();
         n++;
      end
      chk("count_wrap", bus_if.cp0_rdata, 32'd0);

      // Reset overrides a pending exception
      bus_if.wb_to_cp0_bus = mk(1'b1, 5'd5, 32'h0000_ABCD, 1'b0, 32'h0000_3000,
                                1'b0, 5'd0, 32'd0, 1'b0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      rd(5'd14, 32'h0000_0000, "mrst_epc");
      rd(5'd12, 32'h0040_0000, "mrst_status");
      rd(5'd8,  32'h0000_0000, "mrst_badvaddr");
      rd(5'd9,  32'h0000_0000, "mrst_count");
      chk("mrst_int_req", {31'd0, bus_if.int_req}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
